// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/LS memory port arbiter: widths, access-length
// and owner encodings, and the arbiter state type.
package mem_port_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic [0:0] {
        ST_LS_PRIO = 1'b0,
        ST_IF_PRIO = 1'b1
    } arb_state_e;

    // A granted access expects a response only when it is a read
    function automatic logic expects_resp(input logic mem_en, input logic mem_we);
        return mem_en & ~mem_we;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_resp_pipe.sv
// READ_LAT-deep {valid, owner} delay line that tracks which requester owns
// each read returning from the memory macro.
module mem_resp_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] owner_r;

    // Shift one stage per cycle; reset drops every read still in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= '0;
            owner_r <= '0;
        end else begin
            valid_r[0] <= in_valid;
            owner_r[0] <= in_owner;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                owner_r[i] <= owner_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_owner = owner_r[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported data memory between instruction fetch and
// load/store, LS first with a starvation guard that periodically lets IF through.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = mem_port_arbiter_pkg::XLEN,
    parameter int READ_LAT   = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            o_if_gnt,
    output logic            o_if_rvalid,
    output logic [XLEN-1:0] o_if_rdata,
    input  logic            i_ls_req,
    input  logic            i_ls_we,
    input  logic [XLEN-1:0] i_ls_addr,
    input  logic [XLEN-1:0] i_ls_wdata,
    input  logic [1:0]      i_ls_len,
    output logic            o_ls_gnt,
    output logic            o_ls_rvalid,
    output logic [XLEN-1:0] o_ls_rdata,
    output logic            o_mem_en,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [1:0]      o_mem_len,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE - 1);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic [3:0] starve_cnt_r;
    logic [3:0] starve_cnt_nxt_s;
    logic       if_gnt_s;
    logic       ls_gnt_s;
    logic       tail_valid_s;
    logic       tail_owner_s;

    // Arbiter state and starvation counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_LS_PRIO;
            starve_cnt_r <= 4'd0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Grant selection and next-state; nothing is granted while reset is held
    always_comb begin
        if_gnt_s         = 1'b0;
        ls_gnt_s         = 1'b0;
        state_nxt_s      = state_r;
        starve_cnt_nxt_s = starve_cnt_r;
        if (!rstn) begin
            state_nxt_s      = ST_LS_PRIO;
            starve_cnt_nxt_s = 4'd0;
        end else begin
            case (state_r)
                ST_LS_PRIO: begin
                    if (i_if_req && i_ls_req) begin
                        ls_gnt_s = 1'b1;
                        // Last LS win IF tolerates: hand priority over next cycle
                        if (starve_cnt_r == STARVE_LIMIT) begin
                            state_nxt_s      = ST_IF_PRIO;
                            starve_cnt_nxt_s = 4'd0;
                        end else begin
                            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
                        end
                    end else if (i_if_req) begin
                        if_gnt_s         = 1'b1;
                        starve_cnt_nxt_s = 4'd0;
                    end else if (i_ls_req) begin
                        ls_gnt_s         = 1'b1;
                        starve_cnt_nxt_s = 4'd0;
                    end else begin
                        starve_cnt_nxt_s = 4'd0;
                    end
                end
                ST_IF_PRIO: begin
                    if (i_if_req) begin
                        if_gnt_s = 1'b1;
                    end else if (i_ls_req) begin
                        ls_gnt_s = 1'b1;
                    end else begin
                        if_gnt_s = 1'b0;
                    end
                    state_nxt_s      = ST_LS_PRIO;
                    starve_cnt_nxt_s = 4'd0;
                end
                default: begin
                    state_nxt_s      = ST_LS_PRIO;
                    starve_cnt_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // Memory port mux; idle cycles drive all-zero fields
    always_comb begin
        o_mem_en    = if_gnt_s | ls_gnt_s;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_len   = LEN_B;
        if (if_gnt_s) begin
            o_mem_addr = i_if_addr;
            o_mem_len  = LEN_W;
        end else if (ls_gnt_s) begin
            o_mem_we    = i_ls_we;
            o_mem_addr  = i_ls_addr;
            o_mem_wdata = i_ls_wdata;
            o_mem_len   = i_ls_len;
        end else begin
            o_mem_we = 1'b0;
        end
    end

    mem_resp_pipe #(
        .DEPTH (READ_LAT)
    ) u_resp_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (expects_resp(o_mem_en, o_mem_we)),
        .in_owner  (ls_gnt_s ? OWN_LS : OWN_IF),
        .out_valid (tail_valid_s),
        .out_owner (tail_owner_s)
    );

    assign o_if_gnt    = if_gnt_s;
    assign o_ls_gnt    = ls_gnt_s;
    assign o_if_rvalid = tail_valid_s & (tail_owner_s == OWN_IF);
    assign o_ls_rvalid = tail_valid_s & (tail_owner_s == OWN_LS);
    assign o_if_rdata  = i_mem_rdata;
    assign o_ls_rdata  = i_mem_rdata;

endmodule
